// File: rtl/cs_access_unit.sv
// cs_access_unit: runs one Zicsr instruction against cs_registers (IDLE -> RD -> WB -> RSP).
// Optional build macro CS_ACCESS_RW_X0_NOREAD_EN: CSRRW/CSRRWI with rd=x0 skip the CSR read.
module cs_access_unit #(
    parameter int C_XLEN = 32
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    input  logic              req_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic [11:0]       req_addr_i,
    input  logic [4:0]        req_rs1_idx_i,
    input  logic [4:0]        req_rd_idx_i,
    input  logic [C_XLEN-1:0] req_rs1_data_i,
    output logic              csr_rd_o,
    output logic [11:0]       csr_rd_addr_o,
    input  logic [C_XLEN-1:0] csr_rd_data_i,
    input  logic              csr_illegal_rd_i,
    input  logic              csr_illegal_wr_i,
    output logic              csr_wr_o,
    output logic [11:0]       csr_wr_addr_o,
    output logic [C_XLEN-1:0] csr_wr_data_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [C_XLEN-1:0] rsp_data_o,
    output logic              rsp_illegal_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WB   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]        funct3_q;
    logic [11:0]       addr_q;
    logic [4:0]        rs1_idx_q;
    logic [4:0]        rd_idx_q;
    logic [C_XLEN-1:0] rs1_data_q;
    logic [C_XLEN-1:0] rsp_data_q;
    logic              rsp_illegal_q;

    logic              is_rw;
    logic              read_en;
    logic              write_intent;
    logic              illegal;
    logic              write_ok;
    logic [C_XLEN-1:0] src_operand;
    logic [C_XLEN-1:0] new_value;

    function automatic logic [C_XLEN-1:0] source_operand(
        input logic              imm,
        input logic [4:0]        zimm,
        input logic [C_XLEN-1:0] rs1
    );
        return imm ? {{(C_XLEN-5){1'b0}}, zimm} : rs1;
    endfunction

    function automatic logic [C_XLEN-1:0] rmw_value(
        input logic [1:0]        op,
        input logic [C_XLEN-1:0] old,
        input logic [C_XLEN-1:0] src
    );
        logic [C_XLEN-1:0] v;
        case (op)
            2'b01:   v = src;
            2'b10:   v = old | src;
            2'b11:   v = old & ~src;
            default: v = old;
        endcase
        return v;
    endfunction

    assign is_rw = (funct3_q[1:0] == 2'b01);

`ifdef CS_ACCESS_RW_X0_NOREAD_EN
    assign read_en = !(is_rw && (rd_idx_q == 5'd0));
`else
    logic unused_rd_idx;
    assign read_en       = 1'b1;
    assign unused_rd_idx = ^rd_idx_q;
`endif

    // Set/clear forms with rs1=x0 / zimm=0 are pure reads and must not trip write protection.
    assign write_intent = is_rw || (rs1_idx_q != 5'd0);
    assign illegal      = (funct3_q[1:0] == 2'b00)
                       || (read_en && csr_illegal_rd_i)
                       || (write_intent && csr_illegal_wr_i);
    assign write_ok     = write_intent && !illegal;
    assign src_operand  = source_operand(funct3_q[2], rs1_idx_q, rs1_data_q);
    assign new_value    = rmw_value(funct3_q[1:0], csr_rd_data_i, src_operand);

    // State register
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state <= IDLE;
        end else if (clk_en_i) begin
            state <= state_nxt;
        end
    end

    // Next state and strobes
    always_comb begin
        state_nxt     = state;
        req_ready_o   = 1'b0;
        csr_rd_o      = 1'b0;
        csr_wr_o      = 1'b0;
        csr_wr_data_o = '0;
        rsp_valid_o   = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_i) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                csr_rd_o  = read_en;
                state_nxt = WB;
            end
            WB: begin
                csr_wr_o      = write_ok;
                csr_wr_data_o = new_value;
                state_nxt     = RSP;
            end
            RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            funct3_q   <= '0;
            addr_q     <= '0;
            rs1_idx_q  <= '0;
            rd_idx_q   <= '0;
            rs1_data_q <= '0;
        end else if (clk_en_i && (state == IDLE) && req_i) begin
            funct3_q   <= req_funct3_i;
            addr_q     <= req_addr_i;
            rs1_idx_q  <= req_rs1_idx_i;
            rd_idx_q   <= req_rd_idx_i;
            rs1_data_q <= req_rs1_data_i;
        end
    end

    // Response capture at the end of WB
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            rsp_data_q    <= '0;
            rsp_illegal_q <= 1'b0;
        end else if (clk_en_i && (state == WB)) begin
            rsp_data_q    <= (illegal || !read_en) ? '0 : csr_rd_data_i;
            rsp_illegal_q <= illegal;
        end
    end

    assign csr_rd_addr_o = addr_q;
    assign csr_wr_addr_o = addr_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_cs_access_unit.sv
// Self-checking bench for cs_access_unit with a behavioural cs_registers stub and CSR shadow model.
module tb_cs_access_unit;

`ifdef CS_ACCESS_RW_X0_NOREAD_EN
    localparam bit NOREAD = 1'b1;
`else
    localparam bit NOREAD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        resetb_i = 1'b0;
    logic        clk_en_i = 1'b1;
    logic        req_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i = '0;
    logic [11:0] req_addr_i = '0;
    logic [4:0]  req_rs1_idx_i = '0;
    logic [4:0]  req_rd_idx_i = '0;
    logic [31:0] req_rs1_data_i = '0;
    logic        csr_rd_o;
    logic [11:0] csr_rd_addr_o;
    logic [31:0] csr_rd_data_i = '0;
    logic        csr_illegal_rd_i = 1'b0;
    logic        csr_illegal_wr_i = 1'b0;
    logic        csr_wr_o;
    logic [11:0] csr_wr_addr_o;
    logic [31:0] csr_wr_data_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_illegal_o;

    cs_access_unit #(.C_XLEN(32)) dut (
        .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
        .req_i(req_i), .req_ready_o(req_ready_o), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_rs1_idx_i(req_rs1_idx_i), .req_rd_idx_i(req_rd_idx_i),
        .req_rs1_data_i(req_rs1_data_i), .csr_rd_o(csr_rd_o), .csr_rd_addr_o(csr_rd_addr_o),
        .csr_rd_data_i(csr_rd_data_i), .csr_illegal_rd_i(csr_illegal_rd_i),
        .csr_illegal_wr_i(csr_illegal_wr_i), .csr_wr_o(csr_wr_o), .csr_wr_addr_o(csr_wr_addr_o),
        .csr_wr_data_o(csr_wr_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_illegal_o(rsp_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // Access rules of the stubbed register file
    function automatic bit ill_wr_f(input logic [11:0] a);
        return a[11:10] == 2'b11;
    endfunction

    function automatic bit ill_rd_f(input logic [11:0] a);
        return a == 12'h7FF;
    endfunction

    bit [31:0] mem [4096];
    bit [31:0] shadow [4096];
    int        wr_count = 0;
    int        wc_snap;
    int        n_vec = 0;
    int        n_err = 0;
    logic [11:0] addr_tbl [6];

    always @(posedge clk_i) begin
        if (clk_en_i) begin
            csr_illegal_rd_i <= ill_rd_f(csr_rd_addr_o);
            csr_illegal_wr_i <= ill_wr_f(csr_rd_addr_o);
            if (csr_rd_o) csr_rd_data_i <= mem[csr_rd_addr_o];
            if (csr_wr_o) begin
                mem[csr_wr_addr_o] <= csr_wr_data_o;
                wr_count <= wr_count + 1;
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_req_ready"}, req_ready_o, 1'b1);
        chk1({tag, "_csr_rd"}, csr_rd_o, 1'b0);
        chk1({tag, "_csr_wr"}, csr_wr_o, 1'b0);
        chk1({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
        chk1({tag, "_rsp_illegal"}, rsp_illegal_o, 1'b0);
        chk32({tag, "_rsp_data"}, rsp_data_o, 32'h0);
        chk32({tag, "_rd_addr"}, 32'(csr_rd_addr_o), 32'h0);
        chk32({tag, "_wr_addr"}, 32'(csr_wr_addr_o), 32'h0);
        chk32({tag, "_wr_data"}, csr_wr_data_o, 32'h0);
    endtask

    // One full instruction; expectations derived from the Zicsr rules and the shadow CSR file.
    task automatic txn(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                       input logic [4:0] rd, input logic [31:0] d, input int hold,
                       input int gap, input bit early);
        logic [31:0] old, src, nv, rsp;
        bit rw, noread, intent, ill, wr;
        int wc0;
        old    = shadow[a];
        rw     = (f3[1:0] == 2'b01);
        noread = NOREAD && rw && (rd == 5'd0);
        src    = f3[2] ? {27'd0, r1} : d;
        case (f3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            2'b11:   nv = old & ~src;
            default: nv = old;
        endcase
        intent = rw || (r1 != 5'd0);
        ill    = (f3[1:0] == 2'b00) || (!noread && ill_rd_f(a)) || (intent && ill_wr_f(a));
        wr     = intent && !ill;
        rsp    = (ill || noread) ? 32'h0 : old;
        wc0    = wr_count;

        chk1("req_ready_idle", req_ready_o, 1'b1);
        req_i = 1'b1; req_funct3_i = f3; req_addr_i = a; req_rs1_idx_i = r1;
        req_rd_idx_i = rd; req_rs1_data_i = d; rsp_ready_i = early;
        @(posedge clk_i); #1;
        req_i = 1'b0; req_rs1_data_i = $urandom; req_addr_i = 12'($urandom);
        chk1("rd_strobe", csr_rd_o, !noread);
        chk32("rd_addr", 32'(csr_rd_addr_o), 32'(a));
        chk1("req_ready_busy", req_ready_o, 1'b0);
        chk1("rsp_valid_in_rd", rsp_valid_o, 1'b0);
        @(posedge clk_i); #1;
        chk1("wr_strobe", csr_wr_o, wr);
        chk1("rd_strobe_off_in_wb", csr_rd_o, 1'b0);
        if (wr) begin
            chk32("wr_addr", 32'(csr_wr_addr_o), 32'(a));
            chk32("wr_data", csr_wr_data_o, nv);
        end
        if (gap > 0) begin
            clk_en_i = 1'b0;
            repeat (gap) begin
                @(posedge clk_i); #1;
                chk1("wr_strobe_held", csr_wr_o, wr);
                chk1("rsp_valid_frozen", rsp_valid_o, 1'b0);
            end
            chk32("no_commit_frozen", 32'(wr_count - wc0), 32'h0);
            clk_en_i = 1'b1;
        end
        @(posedge clk_i); #1;
        chk1("rsp_valid", rsp_valid_o, 1'b1);
        chk32("rsp_data", rsp_data_o, rsp);
        chk1("rsp_illegal", rsp_illegal_o, ill);
        chk1("wr_strobe_off_in_rsp", csr_wr_o, 1'b0);
        if (!early) begin
            repeat (hold) begin
                @(posedge clk_i); #1;
                chk1("rsp_valid_hold", rsp_valid_o, 1'b1);
                chk32("rsp_data_hold", rsp_data_o, rsp);
                chk1("rsp_illegal_hold", rsp_illegal_o, ill);
                chk1("req_ready_hold", req_ready_o, 1'b0);
            end
            rsp_ready_i = 1'b1;
        end
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        chk1("rsp_valid_done", rsp_valid_o, 1'b0);
        chk1("req_ready_done", req_ready_o, 1'b1);
        chk32("write_count", 32'(wr_count - wc0), 32'(wr));
        chk32("csr_value", mem[a], wr ? nv : old);
        if (wr) shadow[a] = nv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_tbl = '{12'h300, 12'h305, 12'h340, 12'hF11, 12'h7FF, 12'hC00};
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk_i);
        #1 resetb_i = 1'b1;
        @(posedge clk_i); #1;
        check_reset_outputs("post_rst");

        txn(3'b001, 12'h300, 5'd7, 5'd1, 32'h0000_1800, 0, 0, 1'b0);
        txn(3'b010, 12'h300, 5'd5, 5'd3, 32'h0000_0008, 1, 0, 1'b0);
        txn(3'b001, 12'h300, 5'd2, 5'd4, 32'hFFFF_FFFF, 0, 0, 1'b0);
        txn(3'b111, 12'h300, 5'd3, 5'd4, 32'h5555_5555, 0, 0, 1'b0);
        txn(3'b110, 12'h300, 5'd0, 5'd4, 32'h5555_5555, 0, 0, 1'b0);
        txn(3'b001, 12'hF11, 5'd6, 5'd1, 32'h0000_1234, 0, 0, 1'b0);
        txn(3'b010, 12'hF11, 5'd0, 5'd1, 32'hFFFF_FFFF, 0, 0, 1'b0);
        txn(3'b100, 12'h300, 5'd9, 5'd1, 32'h0000_00FF, 5, 0, 1'b0);
        txn(3'b000, 12'h340, 5'd9, 5'd1, 32'h0000_00FF, 0, 0, 1'b1);
        txn(3'b001, 12'h305, 5'd1, 5'd2, 32'h0000_A5A5, 0, 3, 1'b0);
        txn(3'b001, 12'h340, 5'd8, 5'd0, 32'hCAFE_F00D, 0, 0, 1'b0);
        txn(3'b101, 12'h7FF, 5'd4, 5'd0, 32'h0, 0, 0, 1'b0);

        chk1("idle_before_rst", req_ready_o, 1'b1);
        req_i = 1'b1; req_funct3_i = 3'b001; req_addr_i = 12'h300;
        req_rs1_idx_i = 5'd1; req_rd_idx_i = 5'd1; req_rs1_data_i = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        chk1("rst_rd_strobe", csr_rd_o, 1'b1);
        wc_snap = wr_count;
        resetb_i = 1'b0;
        #1;
        check_reset_outputs("mid_rd_rst");
        #2 resetb_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i); #1;
            chk1("after_rst_no_rsp", rsp_valid_o, 1'b0);
            chk1("after_rst_no_wr", csr_wr_o, 1'b0);
        end
        chk32("after_rst_write_count", 32'(wr_count - wc_snap), 32'h0);
        chk32("after_rst_csr", mem[12'h300], shadow[12'h300]);

        for (int i = 0; i < 40; i++) begin
            txn(3'($urandom_range(0, 7)),
                addr_tbl[$urandom_range(0, 5)],
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                $urandom,
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0,
                ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
